// File: rtl/phrase_ctrl_pkg.sv
// Shared codes for the phrase recognizer controller: notes, tense types,
// result status and controller state encoding.
package phrase_ctrl_pkg;

  typedef enum logic [2:0] {
    NOTE_X = 3'b000,
    NOTE_C = 3'b001,
    NOTE_D = 3'b010,
    NOTE_E = 3'b011,
    NOTE_F = 3'b100,
    NOTE_G = 3'b101,
    NOTE_A = 3'b110,
    NOTE_B = 3'b111
  } note_e;

  typedef enum logic [1:0] {
    TYPE_NONE   = 2'b00,
    TYPE_PAST   = 2'b01,
    TYPE_INF    = 2'b10,
    TYPE_FUTURE = 2'b11
  } type_e;

  localparam logic [1:0] ST_ACCEPTED   = 2'b00;
  localparam logic [1:0] ST_REJECTED   = 2'b01;
  localparam logic [1:0] ST_INCOMPLETE = 2'b10;
  localparam logic [1:0] ST_TIMEOUT    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FEED   = 3'd2,
    S_ISSUE  = 3'd3,
    S_CHECK  = 3'd4,
    S_DRAIN  = 3'd5,
    S_RESULT = 3'd6
  } state_e;

  localparam logic [3:0] CNT_SAT = 4'd15;

  function automatic logic [1:0] src_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/phrase_rr_arbiter.sv
// Two-way round-robin grant for the phrase controller; the served source is
// recorded when the controller reports a result.
module phrase_rr_arbiter
  import phrase_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_served,
  output logic       o_grant
);

  logic r_last_served;

  // Last served source; reset value makes source 0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_served <= 1'b1;
    end else if (i_update) begin
      r_last_served <= i_served;
    end else begin
      r_last_served <= r_last_served;
    end
  end

  // Lone requester wins; on a tie the source not served last wins.
  always_comb begin
    o_grant = 1'b0;
    if (i_req == 2'b11) begin
      o_grant = ~r_last_served;
    end else if (i_req[1]) begin
      o_grant = 1'b1;
    end else begin
      o_grant = 1'b0;
    end
  end

endmodule

// File: rtl/phrase_recognizer_ctrl.sv
// Shares one note-phrase recognizer between two note sources, one phrase at a
// time. Optional idle abort is enabled by defining PHRASE_TIMEOUT_EN.
module phrase_recognizer_ctrl
  import phrase_ctrl_pkg::*;
#(
  parameter int MAX_NOTES      = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req_valid,
  input  logic [1:0] i_req_tone,
  input  logic [5:0] i_req_note,
  input  logic [1:0] i_req_last,
  output logic [1:0] o_req_ready,
  output logic       o_rec_reset,
  output logic       o_rec_ok,
  output logic       o_rec_tone,
  output logic [2:0] o_rec_note,
  input  logic       i_rec_finish,
  input  logic [1:0] i_rec_type,
  output logic       o_res_valid,
  output logic       o_res_id,
  output logic [1:0] o_res_status,
  output logic [1:0] o_res_type,
  output logic [3:0] o_res_count
);

  state_e     r_state;
  logic       r_grant;
  logic       r_clear;
  logic [1:0] r_ready;
  logic       r_rec_ok;
  logic       r_rec_tone;
  logic [2:0] r_rec_note;
  logic       r_last;
  logic [3:0] r_count;
  logic       r_res_valid;
  logic [1:0] r_res_status;
  logic [1:0] r_res_type;

  logic       w_arb_grant;
  logic       w_sel_valid;
  logic       w_sel_tone;
  logic       w_sel_last;
  logic [2:0] w_sel_note;
  logic       w_timeout;

  assign w_sel_valid = i_req_valid[r_grant];
  assign w_sel_tone  = i_req_tone[r_grant];
  assign w_sel_last  = i_req_last[r_grant];
  assign w_sel_note  = r_grant ? i_req_note[5:3] : i_req_note[2:0];

  phrase_rr_arbiter u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req_valid),
    .i_update (r_state == S_RESULT),
    .i_served (r_grant),
    .o_grant  (w_arb_grant)
  );

`ifdef PHRASE_TIMEOUT_EN
  logic [15:0] r_idle;

  // Idle cycles of the granted source while the controller is waiting on it.
  always_ff @(posedge clk) begin
    if (reset || (r_state == S_CLEAR) || w_sel_valid) begin
      r_idle <= 16'd0;
    end else if ((r_state == S_FEED) || (r_state == S_DRAIN)) begin
      r_idle <= r_idle + 16'd1;
    end else begin
      r_idle <= r_idle;
    end
  end

  assign w_timeout = ((r_state == S_FEED) || (r_state == S_DRAIN)) && !w_sel_valid &&
                     (r_idle == 16'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // Phrase sequencing FSM; every output is a register set on the transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_clear      <= 1'b0;
      r_ready      <= 2'b00;
      r_rec_ok     <= 1'b0;
      r_rec_tone   <= 1'b0;
      r_rec_note   <= 3'b000;
      r_last       <= 1'b0;
      r_count      <= 4'd0;
      r_res_valid  <= 1'b0;
      r_res_status <= ST_ACCEPTED;
      r_res_type   <= TYPE_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|i_req_valid) begin
            r_grant <= w_arb_grant;
            r_clear <= 1'b1;
            r_state <= S_CLEAR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          r_clear      <= 1'b0;
          r_count      <= 4'd0;
          r_res_status <= ST_ACCEPTED;
          r_res_type   <= TYPE_NONE;
          r_ready      <= src_onehot(r_grant);
          r_state      <= S_FEED;
        end
        S_FEED: begin
          if (w_timeout) begin
            r_res_status <= ST_TIMEOUT;
            r_res_type   <= TYPE_NONE;
            r_ready      <= 2'b00;
            r_res_valid  <= 1'b1;
            r_state      <= S_RESULT;
          end else if (w_sel_valid) begin
            r_ready    <= 2'b00;
            r_rec_ok   <= 1'b1;
            r_rec_tone <= w_sel_tone;
            r_rec_note <= w_sel_note;
            r_last     <= w_sel_last;
            r_state    <= S_ISSUE;
          end else begin
            r_state <= S_FEED;
          end
        end
        S_ISSUE: begin
          r_rec_ok   <= 1'b0;
          r_rec_tone <= 1'b0;
          r_rec_note <= 3'b000;
          r_count    <= (r_count == CNT_SAT) ? r_count : r_count + 4'd1;
          r_state    <= S_CHECK;
        end
        // Recognizer outputs now reflect the note strobed in ISSUE.
        S_CHECK: begin
          if (i_rec_finish) begin
            r_res_status <= (i_rec_type != TYPE_NONE) ? ST_ACCEPTED : ST_REJECTED;
            r_res_type   <= i_rec_type;
            if (r_last) begin
              r_res_valid <= 1'b1;
              r_state     <= S_RESULT;
            end else begin
              r_ready <= src_onehot(r_grant);
              r_state <= S_DRAIN;
            end
          end else if (r_last) begin
            r_res_status <= ST_INCOMPLETE;
            r_res_valid  <= 1'b1;
            r_state      <= S_RESULT;
          end else if (r_count == 4'(MAX_NOTES)) begin
            r_res_status <= ST_INCOMPLETE;
            r_ready      <= src_onehot(r_grant);
            r_state      <= S_DRAIN;
          end else begin
            r_ready <= src_onehot(r_grant);
            r_state <= S_FEED;
          end
        end
        S_DRAIN: begin
          if (w_timeout) begin
            r_res_status <= ST_TIMEOUT;
            r_res_type   <= TYPE_NONE;
            r_ready      <= 2'b00;
            r_res_valid  <= 1'b1;
            r_state      <= S_RESULT;
          end else if (w_sel_valid && w_sel_last) begin
            r_ready     <= 2'b00;
            r_res_valid <= 1'b1;
            r_state     <= S_RESULT;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_RESULT: begin
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_clear     <= 1'b0;
          r_ready     <= 2'b00;
          r_rec_ok    <= 1'b0;
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = r_ready;
  assign o_rec_reset  = reset | r_clear;
  assign o_rec_ok     = r_rec_ok;
  assign o_rec_tone   = r_rec_tone;
  assign o_rec_note   = r_rec_note;
  assign o_res_valid  = r_res_valid;
  assign o_res_id     = r_grant;
  assign o_res_status = r_res_status;
  assign o_res_type   = r_res_type;
  assign o_res_count  = r_count;

endmodule

// File: tb/tb_phrase_recognizer_ctrl.sv
// Self-checking bench for phrase_recognizer_ctrl with a scripted recognizer
// stand-in and scoreboards for strobes and results.
module tb_phrase_recognizer_ctrl;
  import phrase_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       v  [2] = '{1'b0, 1'b0};
  logic       t  [2] = '{1'b0, 1'b0};
  logic [2:0] nt [2] = '{3'b000, 3'b000};
  logic       l  [2] = '{1'b0, 1'b0};

  logic [1:0] req_valid, req_tone, req_last, req_ready;
  logic [5:0] req_note;
  logic       rec_reset, rec_ok, rec_tone;
  logic [2:0] rec_note;
  logic       rec_finish = 1'b0;
  logic [1:0] rec_type = 2'b00;
  logic       res_valid, res_id;
  logic [1:0] res_status, res_type;
  logic [3:0] res_count;

  assign req_valid = {v[1], v[0]};
  assign req_tone  = {t[1], t[0]};
  assign req_last  = {l[1], l[0]};
  assign req_note  = {nt[1], nt[0]};

  int n_cmp = 0;
  int n_err = 0;
  int ok_cnt = 0;
  int both_err = 0;
  int order_err = 0;
  logic seen_clr = 1'b1;

  typedef struct packed {
    logic       id;
    logic [1:0] st;
    logic [1:0] ty;
    logic [3:0] cnt;
  } res_t;

  res_t       res_q [$];
  logic [3:0] stb_q [$];
  logic [5:0] cfg_q [$];
  logic [3:0] stub_fin_at = 4'd0;
  logic [3:0] stub_idx = 4'd0;
  logic [1:0] stub_type = 2'b00;

  phrase_recognizer_ctrl #(.MAX_NOTES(8), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(rst),
    .i_req_valid(req_valid), .i_req_tone(req_tone), .i_req_note(req_note), .i_req_last(req_last),
    .o_req_ready(req_ready),
    .o_rec_reset(rec_reset), .o_rec_ok(rec_ok), .o_rec_tone(rec_tone), .o_rec_note(rec_note),
    .i_rec_finish(rec_finish), .i_rec_type(rec_type),
    .o_res_valid(res_valid), .o_res_id(res_id), .o_res_status(res_status),
    .o_res_type(res_type), .o_res_count(res_count)
  );

  always #5 clk = ~clk;

  // Recognizer stand-in: finish rises after a scripted number of strobes.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rec_finish = 1'b0; rec_type = 2'b00; stub_idx = 4'd0;
    end else if (rec_reset) begin
      rec_finish = 1'b0; rec_type = 2'b00; stub_idx = 4'd0;
      if (cfg_q.size() > 0) {stub_fin_at, stub_type} = cfg_q.pop_front();
      else {stub_fin_at, stub_type} = 6'd0;
    end else if (rec_ok) begin
      stub_idx = stub_idx + 4'd1;
      if (stub_idx == stub_fin_at) begin
        rec_finish = 1'b1; rec_type = stub_type;
      end
    end
  end

  // Output monitor: pops the scoreboards on every strobe and result pulse.
  initial forever begin
    res_t       e;
    logic [3:0] es;
    @(negedge clk);
    if (req_ready == 2'b11) both_err++;
    if (rec_reset) seen_clr = 1'b1;
    if (rec_ok) begin
      ok_cnt++;
      if (!seen_clr) order_err++;
      n_cmp++;
      if (stb_q.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected: got tone=%0b note=%0d, expected no strobe", rec_tone, rec_note);
      end else begin
        es = stb_q.pop_front();
        if ({rec_tone, rec_note} !== es) begin
          n_err++;
          $display("FAIL strobe: got tone=%0b note=%0d, expected tone=%0b note=%0d",
                   rec_tone, rec_note, es[3], es[2:0]);
        end
      end
    end
    if (res_valid) begin
      seen_clr = 1'b0;
      n_cmp++;
      if (res_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: got id=%0d st=%0d ty=%0d cnt=%0d, expected none",
                 res_id, res_status, res_type, res_count);
      end else begin
        e = res_q.pop_front();
        if ({res_id, res_status, res_type, res_count} !== e) begin
          n_err++;
          $display("FAIL result: got id=%0d st=%0d ty=%0d cnt=%0d, expected id=%0d st=%0d ty=%0d cnt=%0d",
                   res_id, res_status, res_type, res_count, e.id, e.st, e.ty, e.cnt);
        end
      end
    end
  end

  task automatic send_note(input int src, input logic tone, input logic [2:0] note, input logic last);
    logic got = 1'b0;
    v[src] = 1'b1; t[src] = tone; nt[src] = note; l[src] = last;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = req_ready[src];
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL handshake_wait src=%0d: got ready=0, expected ready=1 within 200 cycles", src);
    end else begin
      @(posedge clk);
    end
    #1;
    v[src] = 1'b0; t[src] = 1'b0; nt[src] = 3'b000; l[src] = 1'b0;
  endtask

  task automatic send_phrase(input int src, input logic [15:0] tones, input logic [47:0] notes, input int cnt);
    for (int i = 0; i < cnt; i++) send_note(src, tones[i], notes[3*i +: 3], (i == cnt - 1));
  endtask

  task automatic push_exp(input logic src, input logic [15:0] tones, input logic [47:0] notes,
                          input logic [3:0] fin_at, input logic [1:0] ftype,
                          input logic [1:0] st, input logic [1:0] ty, input int ecnt);
    res_t e;
    cfg_q.push_back({fin_at, ftype});
    for (int i = 0; i < ecnt; i++) stb_q.push_back({tones[i], notes[3*i +: 3]});
    e.id = src; e.st = st; e.ty = ty; e.cnt = 4'(ecnt);
    res_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 400 && res_q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (res_q.size() != 0 || stb_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d results and %0d strobes outstanding, expected 0 and 0",
               name, res_q.size(), stb_q.size());
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (rec_reset !== 1'b1) begin n_err++; $display("FAIL reset_rec_reset: got %b, expected 1", rec_reset); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b, expected 00", req_ready); end
    n_cmp++; if ({rec_ok, rec_tone, rec_note} !== 5'd0) begin n_err++; $display("FAIL reset_rec_ok: got %b, expected 0", rec_ok); end
    n_cmp++; if ({res_valid, res_id, res_status, res_type, res_count} !== 10'd0) begin
      n_err++; $display("FAIL reset_result: got valid=%b cnt=%0d, expected all 0", res_valid, res_count);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (rec_reset !== 1'b0) begin n_err++; $display("FAIL idle_rec_reset: got %b, expected 0", rec_reset); end
  endtask

  task automatic test_accept_past;
    int ok0 = ok_cnt;
    push_exp(1'b0, 16'h0002, 48'({3'b000, 3'b101, 3'b011, 3'b010, 3'b001, 3'b100}), 4'd6, TYPE_PAST, ST_ACCEPTED, TYPE_PAST, 6);
    send_phrase(0, 16'h0002, 48'({3'b000, 3'b101, 3'b011, 3'b010, 3'b001, 3'b100}), 6);
    wait_done("accept_past");
    n_cmp++; if (ok_cnt - ok0 !== 6) begin n_err++; $display("FAIL past_ok_pulses: got %0d, expected 6", ok_cnt - ok0); end
  endtask

  task automatic test_accept_future;
    push_exp(1'b1, 16'h0002, 48'({3'b000, 3'b101, 3'b110, 3'b110, 3'b111, 3'b100}), 4'd6, TYPE_FUTURE, ST_ACCEPTED, TYPE_FUTURE, 6);
    send_phrase(1, 16'h0002, 48'({3'b000, 3'b101, 3'b110, 3'b110, 3'b111, 3'b100}), 6);
    wait_done("accept_future");
  endtask

  task automatic test_reject_drain;
    int ok0 = ok_cnt;
    push_exp(1'b0, 16'h0001, 48'({3'b000, 3'b010, 3'b001, 3'b100}), 4'd1, TYPE_NONE, ST_REJECTED, TYPE_NONE, 1);
    send_phrase(0, 16'h0001, 48'({3'b000, 3'b010, 3'b001, 3'b100}), 4);
    wait_done("reject");
    n_cmp++; if (ok_cnt - ok0 !== 1) begin n_err++; $display("FAIL reject_ok_pulses: got %0d, expected 1", ok_cnt - ok0); end
  endtask

  task automatic test_back_to_back;
    push_exp(1'b0, 16'h0002, 48'({3'b001, 3'b100}), 4'd0, TYPE_NONE, ST_INCOMPLETE, TYPE_NONE, 2);
    push_exp(1'b0, 16'h0000, 48'({3'b101, 3'b011}), 4'd2, TYPE_INF, ST_ACCEPTED, TYPE_INF, 2);
    send_phrase(0, 16'h0002, 48'({3'b001, 3'b100}), 2);
    send_phrase(0, 16'h0000, 48'({3'b101, 3'b011}), 2);
    wait_done("back_to_back");
    n_cmp++; if (order_err !== 0) begin n_err++; $display("FAIL clear_before_strobe: got %0d strobes without clear, expected 0", order_err); end
  endtask

  task automatic test_max_notes;
    logic [15:0] tv = 16'h0000;
    logic [47:0] nv = 48'h0;
    for (int i = 0; i < 10; i++) begin
      tv[i] = i[0];
      nv[3*i +: 3] = 3'((i % 7) + 1);
    end
    push_exp(1'b1, tv, nv, 4'd0, TYPE_NONE, ST_INCOMPLETE, TYPE_NONE, 8);
    send_phrase(1, tv, nv, 10);
    wait_done("max_notes");
  endtask

  task automatic test_arbitration;
    for (int r = 0; r < 2; r++) begin
      push_exp(1'b0, 16'h0000, 48'({3'b010, 3'b001}), 4'd2, TYPE_INF, ST_ACCEPTED, TYPE_INF, 2);
      push_exp(1'b1, 16'h0001, 48'({3'b101, 3'b011}), 4'd2, TYPE_INF, ST_ACCEPTED, TYPE_INF, 2);
      fork
        send_phrase(0, 16'h0000, 48'({3'b010, 3'b001}), 2);
        send_phrase(1, 16'h0001, 48'({3'b101, 3'b011}), 2);
      join
      wait_done("arbitration");
    end
    n_cmp++; if (both_err !== 0) begin n_err++; $display("FAIL ready_exclusive: got %0d cycles with both ready, expected 0", both_err); end
  endtask

  task automatic test_reset_mid_feed;
    cfg_q.push_back(6'd0);
    stb_q.push_back({1'b0, 3'b100});
    send_note(0, 1'b0, 3'b100, 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL midfeed_ready: got %b, expected 01", req_ready); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (rec_reset !== 1'b1) begin n_err++; $display("FAIL midfeed_rec_reset: got %b, expected 1", rec_reset); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if ({req_ready, rec_reset, res_valid} !== 4'b0000) begin
      n_err++; $display("FAIL midfeed_idle: got ready=%b rec_reset=%b res_valid=%b, expected 00 0 0", req_ready, rec_reset, res_valid);
    end
  endtask

`ifdef PHRASE_TIMEOUT_EN
  task automatic test_timeout;
    int cyc = 0;
    push_exp(1'b0, 16'h0000, 48'({3'b100}), 4'd0, TYPE_NONE, ST_TIMEOUT, TYPE_NONE, 1);
    send_note(0, 1'b0, 3'b100, 1'b0);
    for (int k = 0; k < 100 && res_q.size() != 0; k++) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (cyc < 20 || cyc > 24) begin n_err++; $display("FAIL timeout_delay: got %0d cycles, expected 20..24", cyc); end
    wait_done("timeout");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_accept_past();
    test_accept_future();
    test_reject_drain();
    test_back_to_back();
    test_max_notes();
    test_arbitration();
    test_reset_mid_feed();
`ifdef PHRASE_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
